countdown_6: RTL and testbench

- Loadable 6-bit down-counter sequencer with a start/busy/done handshake.
- Counterpart to the free-running 6-bit up-counter used in the multdiv datapath. It is loaded with an iteration count and emits one step strobe per enabled cycle.
- It raises a one-cycle done pulse when the count reaches zero.
- The multdiv control uses it to bound multiply/divide iterations and to signal result-ready.

---
 rtl/countdown_6_pkg.sv | 14 +
 rtl/countdown_6_dec.sv | 13 +
 rtl/countdown_6.sv | 102 ++++++++++
 tb/tb_countdown_6.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/countdown_6_pkg.sv
// Shared constants for the countdown_6 iteration sequencer: state encoding,
// default width and the multdiv iteration count it is normally loaded with.
package countdown_6_pkg;

    localparam int CD_WIDTH = 6;

    // Number of iterations the multdiv control loads for a 32-bit multiply/divide.
    localparam int MULTDIV_ITERS = 32;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] RUN  = 2'b01;
    localparam logic [1:0] DONE = 2'b10;

endpackage

// File: rtl/countdown_6_dec.sv
// dec_6: combinational count-1 with a flag for the final iteration (value==1).
module dec_6 #(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0] val_i,
    output logic [WIDTH-1:0] dec_o,
    output logic             is_one_o
);

    assign dec_o    = val_i - WIDTH'(1);
    assign is_one_o = (val_i == WIDTH'(1));

endmodule

// File: rtl/countdown_6.sv
// Loadable down-counter sequencer with start/busy/done handshake; emits one
// step strobe per consumed iteration and a one-cycle done when the run ends.
module countdown_6
    import countdown_6_pkg::*;
#(
    parameter int WIDTH = CD_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             step,
    output logic             last,
    output logic             done
);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] cnt_dec;
    logic             cnt_is_one;
    logic             load_is_zero;

    dec_6 #(.WIDTH(WIDTH)) u_dec (
        .val_i   (count_q),
        .dec_o   (cnt_dec),
        .is_one_o(cnt_is_one)
    );

    assign load_is_zero = (load_val == '0);

    always_comb begin
        state_d = state_q;
        count_d = count_q;

        unique case (state_q)
            IDLE: begin
                if (start && en) begin
                    if (load_is_zero) begin
                        count_d = '0;
                        state_d = DONE;
                    end else begin
                        count_d = load_val;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                // abort is the only RUN exit that ignores en
                if (abort) begin
                    count_d = '0;
                    state_d = IDLE;
                end else if (en) begin
                    if (cnt_is_one) begin
                        count_d = '0;
                        state_d = DONE;
                    end else begin
                        count_d = cnt_dec;
                    end
                end
            end
            DONE: begin
                if (abort || en) begin
                    state_d = IDLE;
                end
            end
            default: begin
                count_d = '0;
                state_d = IDLE;
            end
        endcase

        // Synchronous active-low clear folded into the d-input mux
        if (!clr) begin
            state_d = IDLE;
            count_d = '0;
        end
    end

    assign busy_d = (state_d == RUN);
    assign done_d = (state_d == DONE);

    always_ff @(posedge clk) begin
        state_q <= state_d;
        count_q <= count_d;
        busy_q  <= busy_d;
        done_q  <= done_d;
    end

    assign count = count_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign step  = busy_q & en & ~abort;
    assign last  = busy_q & cnt_is_one;

endmodule

// File: tb/tb_countdown_6.sv
// Directed self-checking bench for countdown_6: reset, nominal, zero/max
// loads, enable stall, abort and ignored-start scenarios.
module tb_countdown_6;
    import countdown_6_pkg::*;

    logic       clk = 1'b0;
    logic       clr;
    logic       en;
    logic       start;
    logic [5:0] load_val;
    logic       abort;
    logic [5:0] count;
    logic       busy;
    logic       step;
    logic       last;
    logic       done;

    int n_cmp = 0;
    int n_err = 0;

    countdown_6 #(.WIDTH(6)) dut (
        .clk     (clk),
        .clr     (clr),
        .en      (en),
        .start   (start),
        .load_val(load_val),
        .abort   (abort),
        .count   (count),
        .busy    (busy),
        .step    (step),
        .last    (last),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [5:0] n);
        start    = 1'b1;
        load_val = n;
        en       = 1'b1;
        next();
        start    = 1'b0;
    endtask

    // Stimulus-only: advances cycles, tallying step/last until done rises.
    task automatic run_until_done(input int bound, output int steps, output int last_at,
                                  output bit saw_done, output logic busy_at_done);
        steps = 0; last_at = -1; saw_done = 1'b0; busy_at_done = 1'bx;
        for (int i = 0; i < bound; i++) begin
            #1;
            if (done) begin
                saw_done = 1'b1;
                busy_at_done = busy;
                break;
            end
            if (step) begin
                steps++;
                if (last) last_at = steps;
            end
            next();
        end
    endtask

    task automatic test_reset();
        int s, la; bit sd; logic bd;
        clr = 1'b0; en = 1'b1; start = 1'b0; load_val = '0; abort = 1'b0;
        next(); next();
        clr = 1'b1;
        n_cmp++;
        if ({count, busy, done} !== 8'h00) begin
            n_err++; $display("FAIL reset_init: count=%0d busy=%b done=%b expected 0/0/0", count, busy, done);
        end
        do_start(6'd20);
        next(); next(); next();
        n_cmp++;
        if (count !== 6'd17) begin
            n_err++; $display("FAIL reset_prerun: count=%0d expected 17", count);
        end
        clr = 1'b0;
        next(); next();
        clr = 1'b1;
        #1;
        n_cmp++;
        if ({count, busy, done, step} !== 9'h000) begin
            n_err++; $display("FAIL reset_midrun: count=%0d busy=%b done=%b step=%b expected 0/0/0/0",
                              count, busy, done, step);
        end
        do_start(6'd5);
        run_until_done(20, s, la, sd, bd);
        n_cmp++;
        if (!sd || s != 5) begin
            n_err++; $display("FAIL reset_rerun: steps=%0d done_seen=%b expected 5/1", s, sd);
        end
        next();
    endtask

    task automatic test_nominal();
        int s, la; bit sd; logic bd;
        do_start(6'(MULTDIV_ITERS));
        n_cmp++;
        if (count !== 6'd32 || busy !== 1'b1) begin
            n_err++; $display("FAIL nom_load: count=%0d busy=%b expected 32/1", count, busy);
        end
        run_until_done(60, s, la, sd, bd);
        n_cmp++;
        if (s != 32 || !sd) begin
            n_err++; $display("FAIL nom_steps: steps=%0d done_seen=%b expected 32/1", s, sd);
        end
        n_cmp++;
        if (la != 32) begin
            n_err++; $display("FAIL nom_last: last at step %0d expected 32", la);
        end
        n_cmp++;
        if (bd !== 1'b0 || count !== 6'd0) begin
            n_err++; $display("FAIL nom_busy_at_done: busy=%b count=%0d expected 0/0", bd, count);
        end
        next();
        n_cmp++;
        if (done !== 1'b0) begin
            n_err++; $display("FAIL nom_done_width: done=%b expected 0", done);
        end
    endtask

    task automatic test_zero_max();
        int s, la; bit sd; logic bd;
        do_start(6'd0);
        #1;
        n_cmp++;
        if (busy !== 1'b0 || step !== 1'b0 || done !== 1'b1) begin
            n_err++; $display("FAIL zero_load: busy=%b step=%b done=%b expected 0/0/1", busy, step, done);
        end
        next();
        n_cmp++;
        if (done !== 1'b0) begin
            n_err++; $display("FAIL zero_done_width: done=%b expected 0", done);
        end
        do_start(6'd63);
        run_until_done(100, s, la, sd, bd);
        n_cmp++;
        if (s != 63 || !sd || la != 63) begin
            n_err++; $display("FAIL max_steps: steps=%0d last_at=%0d done_seen=%b expected 63/63/1", s, la, sd);
        end
        next();
    endtask

    task automatic test_stall();
        int s, la; bit sd; logic bd;
        do_start(6'd4);
        next(); next();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (count !== 6'd2 || step !== 1'b0 || busy !== 1'b1) begin
                n_err++; $display("FAIL stall_hold%0d: count=%0d step=%b busy=%b expected 2/0/1", i, count, step, busy);
            end
            next();
        end
        en = 1'b1;
        run_until_done(20, s, la, sd, bd);
        n_cmp++;
        if (s != 2 || !sd) begin
            n_err++; $display("FAIL stall_remaining: steps=%0d done_seen=%b expected 2/1", s, sd);
        end
        en = 1'b0;
        next(); next();
        n_cmp++;
        if (done !== 1'b1) begin
            n_err++; $display("FAIL stall_done_hold: done=%b expected 1", done);
        end
        en = 1'b1;
        next();
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL stall_done_release: done=%b busy=%b expected 0/0", done, busy);
        end
    endtask

    task automatic test_abort();
        do_start(6'd10);
        next(); next(); next();
        n_cmp++;
        if (count !== 6'd7) begin
            n_err++; $display("FAIL abort_pre: count=%0d expected 7", count);
        end
        abort = 1'b1;
        #1;
        n_cmp++;
        if (step !== 1'b0) begin
            n_err++; $display("FAIL abort_step: step=%b expected 0", step);
        end
        next();
        abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (count !== 6'd0 || busy !== 1'b0 || done !== 1'b0) begin
                n_err++; $display("FAIL abort_idle%0d: count=%0d busy=%b done=%b expected 0/0/0", i, count, busy, done);
            end
            next();
        end
        do_start(6'd6);
        en = 1'b0;
        abort = 1'b1;
        next();
        abort = 1'b0;
        #1;
        n_cmp++;
        if (count !== 6'd0 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++; $display("FAIL abort_en0: count=%0d busy=%b done=%b expected 0/0/0", count, busy, done);
        end
        en = 1'b1;
        next();
    endtask

    task automatic test_ignored_start();
        int s, la; bit sd; logic bd;
        do_start(6'd5);
        start = 1'b1;
        load_val = 6'd40;
        run_until_done(20, s, la, sd, bd);
        n_cmp++;
        if (s != 5 || !sd) begin
            n_err++; $display("FAIL ign_run_start: steps=%0d done_seen=%b expected 5/1", s, sd);
        end
        next();
        n_cmp++;
        if (busy !== 1'b0 || count !== 6'd0 || done !== 1'b0) begin
            n_err++; $display("FAIL ign_done_start: busy=%b count=%0d done=%b expected 0/0/0", busy, count, done);
        end
        start = 1'b0;
        next(); next();
        en = 1'b0;
        start = 1'b1;
        load_val = 6'd9;
        next(); next();
        #1;
        n_cmp++;
        if (busy !== 1'b0 || count !== 6'd0 || done !== 1'b0) begin
            n_err++; $display("FAIL ign_en0_start: busy=%b count=%0d done=%b expected 0/0/0", busy, count, done);
        end
        start = 1'b0;
        en = 1'b1;
        next();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL ign_en0_not_queued: busy=%b expected 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_zero_max();
        test_stall();
        test_abort();
        test_ignored_start();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
